// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and its
// function-under-test / downstream consumer.
interface truth_table_sweeper_if #(
    parameter int SEL_W = 3
);
    logic                      start;
    logic                      y_in;
    logic [SEL_W-1:0]          sel;
    logic                      busy;
    logic                      done;
    logic [(1<<SEL_W)-1:0]     table_out;
    logic                      match;
    logic [SEL_W:0]            err_count;
    logic [SEL_W-1:0]          first_bad;

    modport master (
        input  start, y_in,
        output sel, busy, done, table_out,
        output match, err_count, first_bad
    );

    modport slave (
        output start, y_in,
        input  sel, busy, done, table_out,
        input  match, err_count, first_bad
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps every select combination into a mux-built function, samples y
// after a settle delay and scores the captured table against EXPECTED.
module truth_table_sweeper #(
    parameter int                    SEL_W    = 3,
    parameter int                    SETTLE   = 2,
    parameter logic [(1<<SEL_W)-1:0] EXPECTED = 8'h96
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.master bus
);
    localparam int N  = 1 << SEL_W;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0]    RELOAD = WW'(SETTLE - 1);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [N-1:0]     table_q, table_d;
    logic             match_q, match_d;
    logic [SEL_W:0]   err_q, err_d;
    logic [SEL_W-1:0] fb_q, fb_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        match_d = match_q;
        err_d   = err_q;
        fb_d    = fb_q;
        unique case (state_q)
            S_IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = S_SETTLE;
                    idx_d   = '0;
                    wait_d  = RELOAD;
                    busy_d  = 1'b1;
                    table_d = '0;
                    err_d   = '0;
                    fb_d    = '0;
                    match_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (wait_q == '0) state_d = S_SAMPLE;
                else wait_d = wait_q - WW'(1);
            end
            S_SAMPLE: begin
                table_d[idx_q] = bus.y_in;
                if (bus.y_in != EXPECTED[idx_q]) begin
                    err_d = err_q + (SEL_W+1)'(1);
                    // Only the first miss of a sweep records its index
                    if (err_q == '0) fb_d = idx_q;
                end
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + SEL_W'(1);
                    sel_d   = idx_q + SEL_W'(1);
                    wait_d  = RELOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                match_d = (err_q == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            match_q <= 1'b0;
            err_q   <= '0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            match_q <= match_d;
            err_q   <= err_d;
            fb_q    <= fb_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.match     = match_q;
    assign bus.err_count = err_q;
    assign bus.first_bad = fb_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench for truth_table_sweeper (SEL_W=3, SETTLE=2).
module tb_truth_table_sweeper;
    localparam int         SEL_W = 3;
    localparam int         N     = 8;
    localparam logic [7:0] EXP   = 8'h96;
    localparam int         LAT   = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_sweeper_if #(.SEL_W(SEL_W)) bus ();

    truth_table_sweeper #(
        .SEL_W(SEL_W),
        .SETTLE(2),
        .EXPECTED(EXP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [7:0] fut;
    assign bus.y_in = fut[bus.sel];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tbl;
        int err;
        int fb;
        int m;
        int due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] f, input int due);
        exp_t e;
        int diff;
        diff  = int'(f ^ EXP);
        e.tbl = int'(f);
        e.err = $countones(diff);
        e.fb  = 0;
        for (int i = N - 1; i >= 0; i--)
            if (diff[i]) e.fb = i;
        e.m   = (e.err == 0) ? 1 : 0;
        e.due = due;
        return e;
    endfunction

    function automatic logic [7:0] good_fn();
        logic [7:0] t;
        for (int i = 0; i < N; i++)
            t[i] = ((i >> 2) & 1) ^ ((i >> 1) & 1) ^ (i & 1);
        return t;
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (bus.done) begin
            check("done_one_cycle", int'(prev_done), 0);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", cyc, e.due);
                check("table_out", int'(bus.table_out), e.tbl);
                check("err_count", int'(bus.err_count), e.err);
                check("first_bad", int'(bus.first_bad), e.fb);
                check("match", int'(bus.match), e.m);
            end
        end
        prev_done <= bus.done;
    end

    task automatic start_sweep(input logic [7:0] f);
        @(negedge clk);
        fut = f;
        bus.start = 1'b1;
        q.push_back(model(f, cyc + LAT));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("sweep_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"}, int'(bus.sel), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_table"}, int'(bus.table_out), 0);
        check({tag, "_match"}, int'(bus.match), 0);
        check({tag, "_err"}, int'(bus.err_count), 0);
        check({tag, "_fb"}, int'(bus.first_bad), 0);
    endtask

    initial begin
        logic [7:0] g;
        int c0;
        g = good_fn();
        fut = 8'h00;
        bus.start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_sweep(g);
        repeat (4) @(negedge clk);
        check("busy_mid", int'(bus.busy), 1);
        wait_empty();
        start_sweep(g ^ 8'h20);
        wait_empty();
        start_sweep(8'h00);
        wait_empty();

        // stray start pulse mid-sweep must not disturb timing
        start_sweep(g);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_empty();

        // held start: three back-to-back sweeps
        @(negedge clk);
        c0 = cyc;
        fut = g ^ 8'h81;
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++)
            q.push_back(model(fut, c0 + LAT * (k + 1)));
        repeat (53) @(negedge clk);
        bus.start = 1'b0;
        wait_empty();

        // reset mid-sweep aborts without a done pulse
        start_sweep(g ^ 8'h0F);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        check_zero("abort");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        start_sweep(g);
        wait_empty();

        for (int k = 0; k < 6; k++) begin
            start_sweep(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_empty();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
